mvau_weight_loader: RTL
=======================

// Module: mvau_weight_loader
// PURPOSE
//  Write-side counterpart of the MVAU weight memory: streams weights in at runtime instead of $readmemh.
//  Accepts an AXI-Stream of IN_BW-bit beats and packs them into SIMD*TW-bit words.
//  Writes words to sequential weight-memory addresses 0..WMEM_DEPTH-1.
//  Holds the MVAU reader off via wmem_rd_lock until a full image is committed.
// PARAMETERS
//  SIMD          2   input-channel parallelism; word = SIMD*TW bits
//  TW            1   weight bit width
//  WMEM_DEPTH    4   words per weight memory (KDim^2*IFMCh*OFMCh/(SIMD*PE))
//  WMEM_ADDR_BW  4   address width; 2**WMEM_ADDR_BW >= WMEM_DEPTH
//  IN_BW         8   stream beat width
// PORTS
//  aclk           in   1             main clock
//  areset         in   1             synchronous reset, active-high
//  load_start     in   1             1-cycle pulse: begin loading a full weight image
//  s_axis_tdata   in   IN_BW         weight beat; lowest chunk of a word arrives first
//  s_axis_tvalid  in   1             beat valid
//  s_axis_tready  out  1             beat accepted when tvalid&tready
//  wmem_wr_en     out  1             weight memory write strobe
//  wmem_wr_addr   out  WMEM_ADDR_BW  write address
//  wmem_wr_data   out  SIMD*TW       write word
//  wmem_rd_lock   out  1             high while loading; MVAU must not read weights
//  load_busy      out  1             FSM not IDLE
//  load_done      out  1             1-cycle pulse: image fully written
//  wload_csum     out  SIMD*TW       XOR checksum (see CONFIGURATION)
// BEHAVIOUR
//  Clock and reset: one clock (aclk); reset is synchronous, active-high.
//  Reset values: all outputs 0; FSM=IDLE; beat counter, address counter, packer cleared.
//  BEATS = ceil(SIMD*TW/IN_BW).
//    Beat k fills bits [k*IN_BW +: IN_BW] of the word.
//    Bits of the last beat beyond SIMD*TW are discarded.
//  FSM states:
//    IDLE: load_start=1 -> LOAD; else stay.
//    LOAD: accept beats. After the final beat of word WMEM_DEPTH-1 is accepted -> FLUSH.
//    FLUSH: final write issues -> DONE.
//    DONE: load_done=1 for exactly this cycle -> IDLE.
//  Ready: s_axis_tready = (state==LOAD); beats are never buffered outside LOAD.
//  Back-pressure: tvalid low in LOAD stalls with no side effects; there is no timeout.
//  Write timing: registered. wmem_wr_en=1 exactly one cycle after the final beat of each word is accepted.
//    wr_addr/wr_data are valid in that same cycle; otherwise wr_en=0.
//  Throughput: continuous tvalid gives one word per BEATS cycles.
//  Address: increments after each write; address 0 at each load_start; never wraps within a load.
//  Lock timing: wmem_rd_lock=1 from the cycle after load_start through FLUSH; 0 in DONE and IDLE.
//  load_busy = (state != IDLE).
//  Simultaneous events:
//    load_start while not IDLE: ignored.
//    load_start in the same cycle as areset: reset wins.
//  Reset mid-load: abort immediately to IDLE; no further writes; load_done not pulsed.
//    Memory contents are then undefined until the next complete load.
//  Extra beats: beats arriving after FLUSH are not accepted (tready=0) and remain for the next load.
// CONFIGURATION
//  `WLOAD_CHECKSUM_EN defined:
//    wload_csum accumulates the XOR of every word written; cleared at load_start and at reset.
//    Its value is final and stable from the DONE cycle until the next load_start.
//  Not defined: wload_csum is tied to 0; no accumulator logic is synthesised.
// STRUCTURE
//  Package mvau_wload_pkg:
//    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} wload_state_t;
//    function beats_per_word(simd, tw, in_bw).
//  Sub-module mvau_wload_packer: beat counter plus shift/assemble register.
//    Emits word_valid and word on the final beat; cleared by areset or by start.
//  Top: FSM, address counter, output registers, optional checksum.
// TESTING (SIMD=2, TW=4, IN_BW=4, WMEM_DEPTH=4, WMEM_ADDR_BW=2)
//  1. Reset: hold areset 3 cycles -> all outputs 0, tready=0.
//     load_start then beats 0x3,0xA -> wr_en at addr0, data 0xA3, one cycle after 2nd beat.
//  2. Full load: 8 beats 0x1..0x8 back-to-back.
//     -> writes 0x21@0, 0x43@1, 0x65@2, 0x87@3; load_done 2 cycles after 8th beat.
//     -> with the checksum macro: wload_csum=0x21^0x43^0x65^0x87=0x80.
//  3. Stalls: drop tvalid for 5 cycles mid-word -> no write, no state change; data identical to scenario 2.
//  4. load_start pulsed during LOAD -> ignored; address continues, single load_done.
//  5. areset after 3 words -> IDLE next cycle, no 4th write, no load_done.
//     New load restarts at addr0.
//  6. 10 beats offered -> only 8 accepted, tready=0 from FLUSH onward.
//     Beats 9-10 load into addr0 on the next load.
//  Without `WLOAD_CHECKSUM_EN: wload_csum stays 0 in every scenario.

Source files
------------

// File: rtl/mvau_wload_pkg.sv
// Shared types and helpers for the MVAU runtime weight loader.
package mvau_wload_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} wload_state_t;

    function automatic int unsigned beats_per_word(input int unsigned simd,
                                                   input int unsigned tw,
                                                   input int unsigned in_bw);
        return (simd * tw + in_bw - 1) / in_bw;
    endfunction

endpackage

// File: rtl/mvau_weight_loader_if.sv
// Weight-stream input and weight-memory write bus of the MVAU weight loader.
interface mvau_weight_loader_if #(
    parameter int unsigned SIMD         = 2,
    parameter int unsigned TW           = 1,
    parameter int unsigned WMEM_ADDR_BW = 4,
    parameter int unsigned IN_BW        = 8
);
    logic [IN_BW-1:0]        s_axis_tdata;
    logic                    s_axis_tvalid;
    logic                    s_axis_tready;
    logic                    wmem_wr_en;
    logic [WMEM_ADDR_BW-1:0] wmem_wr_addr;
    logic [SIMD*TW-1:0]      wmem_wr_data;
    logic                    wmem_rd_lock;

    // Loader side: sinks the stream, drives the memory write port.
    modport slave (
        input  s_axis_tdata, s_axis_tvalid,
        output s_axis_tready, wmem_wr_en, wmem_wr_addr, wmem_wr_data, wmem_rd_lock
    );

    // Environment side: stream source and memory/reader.
    modport master (
        output s_axis_tdata, s_axis_tvalid,
        input  s_axis_tready, wmem_wr_en, wmem_wr_addr, wmem_wr_data, wmem_rd_lock
    );
endinterface

// File: rtl/mvau_wload_packer.sv
// Beat counter and assemble register: packs IN_BW-bit beats (lowest chunk first) into one word.
module mvau_wload_packer
    import mvau_wload_pkg::*;
#(
    parameter int unsigned SIMD  = 2,
    parameter int unsigned TW    = 1,
    parameter int unsigned IN_BW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 beat_valid,
    input  logic [IN_BW-1:0]     beat,
    output logic                 word_valid,
    output logic [SIMD*TW-1:0]   word
);
    localparam int unsigned WORD_BW = SIMD * TW;
    localparam int unsigned BEATS   = beats_per_word(SIMD, TW, IN_BW);
    localparam int unsigned PACK_BW = BEATS * IN_BW;
    localparam int unsigned CNT_BW  = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_BW-1:0]  cnt_q, cnt_d;
    logic [PACK_BW-1:0] acc_q, acc_d;
    logic               last_beat;

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        last_beat = (cnt_q == CNT_BW'(BEATS - 1));
        if (start) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (beat_valid) begin
            acc_d[int'(cnt_q) * IN_BW +: IN_BW] = beat;
            cnt_d = last_beat ? '0 : cnt_q + CNT_BW'(1);
        end
    end

    // Word is taken from the next-state image so the final beat is included this cycle;
    // any last-beat bits above WORD_BW are dropped here.
    assign word_valid = beat_valid & last_beat & ~start;
    assign word       = acc_d[WORD_BW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mvau_weight_loader.sv
// Runtime weight loader for the MVAU weight memory: FSM, address counter, write port, read lock.
// Optional XOR checksum of written words enabled by defining WLOAD_CHECKSUM_EN.
module mvau_weight_loader
    import mvau_wload_pkg::*;
#(
    parameter int unsigned SIMD         = 2,
    parameter int unsigned TW           = 1,
    parameter int unsigned WMEM_DEPTH   = 4,
    parameter int unsigned WMEM_ADDR_BW = 4,
    parameter int unsigned IN_BW        = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  load_start,
    mvau_weight_loader_if.slave   wbus,
    output logic                  load_busy,
    output logic                  load_done,
    output logic [SIMD*TW-1:0]    wload_csum
);
    localparam int unsigned WORD_BW = SIMD * TW;

    wload_state_t            state_q, state_d;
    logic [WMEM_ADDR_BW-1:0] addr_q, addr_d;
    logic                    wr_en_q, wr_en_d;
    logic [WMEM_ADDR_BW-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_BW-1:0]      wr_data_q, wr_data_d;
    logic                    tready_q, tready_d;
    logic                    lock_q, lock_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    start_go;
    logic                    word_valid;
    logic [WORD_BW-1:0]      word;

    assign start_go = (state_q == IDLE) && load_start;

    mvau_wload_packer #(
        .SIMD  (SIMD),
        .TW    (TW),
        .IN_BW (IN_BW)
    ) u_packer (
        .clk        (aclk),
        .rst        (areset),
        .start      (start_go),
        .beat_valid (wbus.s_axis_tvalid & tready_q),
        .beat       (wbus.s_axis_tdata),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    addr_d  = '0;
                end
            end
            LOAD: begin
                if (word_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = word;
                    addr_d    = addr_q + WMEM_ADDR_BW'(1);
                    if (addr_q == WMEM_ADDR_BW'(WMEM_DEPTH - 1)) state_d = FLUSH;
                end
            end
            FLUSH:   state_d = DONE;
            default: state_d = IDLE;
        endcase
        // Status outputs are registered from the next state so they line up with it.
        tready_d = (state_d == LOAD);
        lock_d   = (state_d == LOAD) || (state_d == FLUSH);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            tready_q  <= 1'b0;
            lock_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            tready_q  <= tready_d;
            lock_q    <= lock_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign wbus.s_axis_tready = tready_q;
    assign wbus.wmem_wr_en    = wr_en_q;
    assign wbus.wmem_wr_addr  = wr_addr_q;
    assign wbus.wmem_wr_data  = wr_data_q;
    assign wbus.wmem_rd_lock  = lock_q;
    assign load_busy          = busy_q;
    assign load_done          = done_q;

`ifdef WLOAD_CHECKSUM_EN
    logic [WORD_BW-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start_go) begin
            csum_d = '0;
        end else if (word_valid) begin
            csum_d = csum_q ^ word;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign wload_csum = csum_q;
`else
    assign wload_csum = '0;
`endif
endmodule
